// File: rtl/mem_arbiter.sv
// Two-master, one-slave physical memory bus arbiter with round-robin or fixed
// priority, a per-transaction slave timeout, and a sticky abort error flag.
module mem_arbiter #(
    parameter int          TIMEOUT    = 1024,
    parameter logic [31:0] ABORT_DATA = 32'hFFFF_FFFF,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_a,
    input  logic [31:0] m1_a,
    input  logic [31:0] m0_d,
    input  logic [31:0] m1_d,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic        m0_rd,
    input  logic        m1_rd,
    output logic [31:0] m0_spo,
    output logic [31:0] m1_spo,
    output logic        m0_ready,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    output logic [1:0]  grant,
    output logic        irq,
    output logic        err,
    output logic        err_src,
    input  logic        err_clr
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    state_t        state;
    logic          owner;
    logic          last;
    logic [CW-1:0] cnt;

    logic req0;
    logic req1;
    logic own_req;
    logic pick;

    assign req0    = m0_rd | m0_we;
    assign req1    = m1_rd | m1_we;
    assign own_req = owner ? req1 : req0;
    // On a tie round-robin favours whoever was not granted last.
    assign pick    = (req0 & req1) ? (FIXED_PRIO ? 1'b0 : ~last) : req1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            cnt     <= '0;
            irq     <= 1'b0;
            err     <= 1'b0;
            err_src <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (err_clr)
                err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state <= pick ? GNT1 : GNT0;
                        owner <= pick;
                        last  <= pick;
                        cnt   <= '0;
                    end
                end
                GNT0, GNT1: begin
                    if (s_ready || !own_req) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state <= ABORT;
                        irq   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ABORT: begin
                    state   <= IDLE;
                    err     <= 1'b1;
                    err_src <= owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The slave path is a pure mux of the owning master, so a combinational
    // s_ready reaches the master in the same cycle.
    always_comb begin
        s_a      = '0;
        s_d      = '0;
        s_we     = 1'b0;
        s_rd     = 1'b0;
        m0_spo   = '0;
        m1_spo   = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        grant    = 2'b00;
        case (state)
            GNT0: begin
                s_a      = m0_a;
                s_d      = m0_d;
                s_we     = m0_we;
                s_rd     = m0_rd;
                m0_spo   = s_spo;
                m0_ready = s_ready;
                grant    = 2'b01;
            end
            GNT1: begin
                s_a      = m1_a;
                s_d      = m1_d;
                s_we     = m1_we;
                s_rd     = m1_rd;
                m1_spo   = s_spo;
                m1_ready = s_ready;
                grant    = 2'b10;
            end
            ABORT: begin
                grant = owner ? 2'b10 : 2'b01;
                if (owner) begin
                    m1_ready = 1'b1;
                    m1_spo   = ABORT_DATA;
                end else begin
                    m0_ready = 1'b1;
                    m0_spo   = ABORT_DATA;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share one
// input set and are both checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] m0_a = '0, m1_a = '0, m0_d = '0, m1_d = '0, s_spo = '0;
    logic        m0_we = 0, m1_we = 0, m0_rd = 0, m1_rd = 0, s_ready = 0, err_clr = 0;

    logic [31:0] o_m0_spo [2];
    logic [31:0] o_m1_spo [2];
    logic [31:0] o_s_a    [2];
    logic [31:0] o_s_d    [2];
    logic        o_m0_ready [2];
    logic        o_m1_ready [2];
    logic        o_s_we   [2];
    logic        o_s_rd   [2];
    logic        o_irq    [2];
    logic        o_err    [2];
    logic        o_err_src[2];
    logic [1:0]  o_grant  [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO), .ABORT_DATA(32'hFFFF_FFFF), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m1_a(m1_a), .m0_d(m0_d), .m1_d(m1_d),
        .m0_we(m0_we), .m1_we(m1_we), .m0_rd(m0_rd), .m1_rd(m1_rd),
        .m0_spo(o_m0_spo[0]), .m1_spo(o_m1_spo[0]),
        .m0_ready(o_m0_ready[0]), .m1_ready(o_m1_ready[0]),
        .s_a(o_s_a[0]), .s_d(o_s_d[0]), .s_we(o_s_we[0]), .s_rd(o_s_rd[0]),
        .s_spo(s_spo), .s_ready(s_ready),
        .grant(o_grant[0]), .irq(o_irq[0]), .err(o_err[0]), .err_src(o_err_src[0]),
        .err_clr(err_clr)
    );

    mem_arbiter #(.TIMEOUT(TO), .ABORT_DATA(32'hFFFF_FFFF), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m1_a(m1_a), .m0_d(m0_d), .m1_d(m1_d),
        .m0_we(m0_we), .m1_we(m1_we), .m0_rd(m0_rd), .m1_rd(m1_rd),
        .m0_spo(o_m0_spo[1]), .m1_spo(o_m1_spo[1]),
        .m0_ready(o_m0_ready[1]), .m1_ready(o_m1_ready[1]),
        .s_a(o_s_a[1]), .s_d(o_s_d[1]), .s_we(o_s_we[1]), .s_rd(o_s_rd[1]),
        .s_spo(s_spo), .s_ready(s_ready),
        .grant(o_grant[1]), .irq(o_irq[1]), .err(o_err[1]), .err_src(o_err_src[1]),
        .err_clr(err_clr)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bus (-1 = nobody), how long it has
    // waited, whether it is in its abort cycle, and the error flags.
    int own    [2];
    int waited [2];
    bit abt    [2];
    int last   [2];
    bit err_m  [2];
    bit esrc_m [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                own[k] = -1; waited[k] = 0; abt[k] = 0;
                last[k] = 1; err_m[k] = 0; esrc_m[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit r0, r1, rx;
                int w;
                r0 = m0_rd | m0_we;
                r1 = m1_rd | m1_we;
                if (abt[k]) begin
                    err_m[k]  = 1;
                    esrc_m[k] = (own[k] == 1);
                    own[k]    = -1;
                    abt[k]    = 0;
                end else begin
                    if (err_clr) err_m[k] = 0;
                    if (own[k] < 0) begin
                        if (r0 && r1)  w = (k == 1) ? 0 : 1 - last[k];
                        else if (r0)   w = 0;
                        else if (r1)   w = 1;
                        else           w = -1;
                        if (w >= 0) begin
                            own[k] = w; waited[k] = 0; last[k] = w;
                        end
                    end else begin
                        rx = (own[k] == 1) ? r1 : r0;
                        if (s_ready || !rx)        own[k] = -1;
                        else if (waited[k] == TO - 1) abt[k] = 1;
                        else                       waited[k]++;
                    end
                end
            end
        end
    end

    logic [31:0] e_m0_spo, e_m1_spo, e_s_a, e_s_d;
    logic        e_m0_rdy, e_m1_rdy, e_we, e_rd, e_irq;
    logic [1:0]  e_grant;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                e_m0_spo = '0; e_m1_spo = '0; e_s_a = '0; e_s_d = '0;
                e_m0_rdy = 0; e_m1_rdy = 0; e_we = 0; e_rd = 0; e_irq = 0; e_grant = 2'b00;
                if (rst && own[k] >= 0) begin
                    e_grant = (own[k] == 1) ? 2'b10 : 2'b01;
                    if (abt[k]) begin
                        e_irq = 1;
                        if (own[k] == 1) begin e_m1_rdy = 1; e_m1_spo = 32'hFFFF_FFFF; end
                        else             begin e_m0_rdy = 1; e_m0_spo = 32'hFFFF_FFFF; end
                    end else if (own[k] == 0) begin
                        e_s_a = m0_a; e_s_d = m0_d; e_we = m0_we; e_rd = m0_rd;
                        e_m0_spo = s_spo; e_m0_rdy = s_ready;
                    end else begin
                        e_s_a = m1_a; e_s_d = m1_d; e_we = m1_we; e_rd = m1_rd;
                        e_m1_spo = s_spo; e_m1_rdy = s_ready;
                    end
                end
                check_output($sformatf("grant[%0d]", k),    32'(o_grant[k]),    32'(e_grant));
                check_output($sformatf("s_we[%0d]", k),     32'(o_s_we[k]),     32'(e_we));
                check_output($sformatf("s_rd[%0d]", k),     32'(o_s_rd[k]),     32'(e_rd));
                check_output($sformatf("m0_ready[%0d]", k), 32'(o_m0_ready[k]), 32'(e_m0_rdy));
                check_output($sformatf("m1_ready[%0d]", k), 32'(o_m1_ready[k]), 32'(e_m1_rdy));
                check_output($sformatf("m0_spo[%0d]", k),   o_m0_spo[k],        e_m0_spo);
                check_output($sformatf("m1_spo[%0d]", k),   o_m1_spo[k],        e_m1_spo);
                check_output($sformatf("irq[%0d]", k),      32'(o_irq[k]),      32'(e_irq));
                check_output($sformatf("err[%0d]", k),      32'(o_err[k]),      32'(rst ? err_m[k] : 1'b0));
                check_output($sformatf("err_src[%0d]", k),  32'(o_err_src[k]),  32'(rst ? esrc_m[k] : 1'b0));
                if (!(rst && abt[k])) begin
                    check_output($sformatf("s_a[%0d]", k), o_s_a[k], e_s_a);
                    check_output($sformatf("s_d[%0d]", k), o_s_d[k], e_s_d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus();
        if (!rst)                             rst = 1;
        else if ($urandom_range(0, 599) == 0) rst = 0;
        if ($urandom_range(0, 7) == 0) m0_rd = ~m0_rd;
        if ($urandom_range(0, 7) == 0) m1_rd = ~m1_rd;
        if ($urandom_range(0, 15) == 0) m0_we = ~m0_we;
        if ($urandom_range(0, 15) == 0) m1_we = ~m1_we;
        m0_a = $urandom; m1_a = $urandom; m0_d = $urandom; m1_d = $urandom; s_spo = $urandom;
        err_clr = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        bit quiet;
        int we_cycles;
        logic [1:0] rr_exp [4];
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

        // Reset
        step(); cmp_en = 1; step();
        rst = 1; #1;
        check_output("reset_grant", 32'(o_grant[0]), 32'h0);
        check_output("reset_err",   32'(o_err[0]),   32'h0);

        // Single zero-wait read from master 0
        m0_rd = 1; m0_a = 32'h1000; s_ready = 1; s_spo = 32'h1234_5678; #1;
        check_output("read_idle_s_rd", 32'(o_s_rd[0]), 32'h0);
        step();
        check_output("read_s_rd",     32'(o_s_rd[0]),     32'h1);
        check_output("read_s_a",      o_s_a[0],           32'h1000);
        check_output("read_m0_spo",   o_m0_spo[0],        32'h1234_5678);
        check_output("read_m0_ready", 32'(o_m0_ready[0]), 32'h1);
        m0_rd = 0; s_ready = 0; step();
        check_output("read_done_grant", 32'(o_grant[0]), 32'h0);

        // Simultaneous requests, fresh reset so master 0 wins first
        rst = 0; step(); rst = 1; step();
        for (int r = 0; r < 4; r++) begin
            m0_rd = 1; m1_rd = 1; s_ready = 1;
            step();
            check_output($sformatf("rr_order%0d", r), 32'(o_grant[0]), 32'(rr_exp[r]));
            check_output($sformatf("fp_order%0d", r), 32'(o_grant[1]), 32'h1);
            m0_rd = 0; m1_rd = 0;
            step();
        end
        s_ready = 0;

        // Master 1 write with five wait states
        m1_we = 1; m1_a = 32'h2000; m1_d = 32'hCAFE_BABE;
        step();
        we_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            s_ready = (i == 5); #1;
            if (o_s_we[0]) we_cycles++;
            check_output("wr_s_d",     o_s_d[0],           32'hCAFE_BABE);
            check_output("wr_m0_rdy",  32'(o_m0_ready[0]), 32'h0);
            step();
        end
        m1_we = 0; s_ready = 0; #1;
        check_output("wr_we_cycles", 32'(we_cycles), 32'd6);

        // Timeout abort
        m0_rd = 1; m0_a = 32'h3000;
        step();
        check_output("to_grant", 32'(o_grant[0]), 32'h1);
        for (int i = 1; i < TO; i++) begin
            step();
            check_output("to_no_irq", 32'(o_irq[0]), 32'h0);
        end
        step();
        check_output("to_irq",      32'(o_irq[0]),      32'h1);
        check_output("to_m0_ready", 32'(o_m0_ready[0]), 32'h1);
        check_output("to_m0_spo",   o_m0_spo[0],        32'hFFFF_FFFF);
        m0_rd = 0; step();
        check_output("to_irq_off",  32'(o_irq[0]),     32'h0);
        check_output("to_err",      32'(o_err[0]),     32'h1);
        check_output("to_err_src",  32'(o_err_src[0]), 32'h0);
        err_clr = 1; step(); err_clr = 0; #1;
        check_output("to_err_clr",  32'(o_err[0]), 32'h0);

        // Ready on the last counted cycle completes normally
        m0_rd = 1;
        step();
        for (int i = 0; i < TO - 1; i++) step();
        s_ready = 1; #1;
        check_output("edge_m0_ready", 32'(o_m0_ready[0]), 32'h1);
        check_output("edge_no_irq",   32'(o_irq[0]),      32'h0);
        step();
        m0_rd = 0; s_ready = 0; #1;
        check_output("edge_idle_irq", 32'(o_irq[0]), 32'h0);
        check_output("edge_err",      32'(o_err[0]), 32'h0);

        // Reset in the middle of a slow read, request held across it
        m0_rd = 1;
        step(); step(); step();
        rst = 0; #1;
        check_output("mid_rst_s_rd",  32'(o_s_rd[0]),  32'h0);
        check_output("mid_rst_grant", 32'(o_grant[0]), 32'h0);
        step(); rst = 1;
        step();
        check_output("regrant", 32'(o_grant[0]), 32'h1);
        s_ready = 1; step();
        m0_rd = 0; s_ready = 0; step();

        // Randomised traffic with quiet stretches to provoke timeouts
        quiet = 0;
        for (int c = 0; c < 4000; c++) begin
            apply_stimulus();
            if ($urandom_range(0, 19) == 0) quiet = ~quiet;
            s_ready = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
            step();
        end

        rst = 1;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter on the physical memory bus, between the requesters and `mmapper`. Master 0 is the CPU/MMU physical port (`pa/pd/pwe/prd`). Master 1 is a DMA-class requester, such as an SD-to-memory copier or a video fetcher. The arbiter serialises whole transactions with round-robin or fixed priority. It also aborts any transaction whose slave never returns `ready` and raises an error interrupt for it.

## Interface
- `TIMEOUT`, 1024: cycles a granted transaction may wait for slave `ready` before it is aborted; must be ≥2.
- `ABORT_DATA`, 32'hFFFF_FFFF: read data returned to the master on an aborted transaction.
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = master 0 always wins a tie.
- `clk` in 1: single clock (`clk_main` domain).
- `rst` in 1: reset, asynchronous, active-low. Everything below is in the clk domain.
- `m0_a`, `m1_a` in 32: master addresses.
- `m0_d`, `m1_d` in 32: master write data.
- `m0_we`, `m1_we`, `m0_rd`, `m1_rd` in 1: master requests, level, held until `mX_ready`.
- `m0_spo`, `m1_spo` out 32: read data to the master.
- `m0_ready`, `m1_ready` out 1: one-cycle completion strobe to the master.
- `s_a` out 32, `s_d` out 32, `s_we` out 1, `s_rd` out 1: to `mmapper`.
- `s_spo` in 32, `s_ready` in 1: from `mmapper`; `s_ready` may be combinational.
- `grant` out 2: one-hot current owner; 00 when idle.
- `irq` out 1: one-cycle pulse on timeout abort.
- `err` out 1: sticky timeout flag.
- `err_src` out 1: master whose transaction was last aborted.
- `err_clr` in 1: clears `err`.

## Operation
- States are IDLE, GNT0, GNT1 and ABORT. `last` (1 bit) records the most recently granted master; reset value is 1, so master 0 wins first.
- Request from master X is `mX_rd | mX_we`. Both asserted together is passed through unchanged; this block does not check it.
- IDLE:
  - One request: go to GNTX.
  - Two requests: with `FIXED_PRIO=0`, go to GNT(~last); otherwise GNT0.
  - On entering GNTX: set `last`=X and clear `cnt` to 0.
  - All `s_*` controls are 0. Both `mX_ready` are 0. `grant`=00.
- GNTX:
  - `s_a/s_d/s_we/s_rd` = master X signals, combinationally.
  - `mX_spo` = `s_spo` and `mX_ready` = `s_ready`.
  - The other master sees `ready`=0 and `spo`=0.
  - If `s_ready`: go to IDLE.
  - Else if master X drops its request: go to IDLE silently (no abort, no irq).
  - Else if `cnt == TIMEOUT-1`: go to ABORT.
  - Else `cnt++`.
  - `cnt` width is `$clog2(TIMEOUT)`; it never wraps.
- ABORT, one cycle:
  - `s_we`=`s_rd`=0.
  - `mX_ready`=1 and `mX_spo`=`ABORT_DATA`.
  - `irq`=1, `err` set, `err_src`=X.
  - Next state IDLE.
- A master must deassert its request the cycle after it sees `ready`. A request still high in IDLE is treated as a new transaction.
- `err_clr` in the same cycle as an abort: the set wins.
- Reset, at any time including mid-transaction: go to IDLE immediately. All outputs go to 0: `grant`, `irq`, `err`, `err_src`, `mX_ready`, `mX_spo` and `s_*`. `last` goes to 1. An in-flight slave access is dropped; the master is never acknowledged.

## Timing
- Arbitration latency is 1 cycle. A request first seen in IDLE at cycle N drives `s_rd`/`s_we` from cycle N+1.
- Minimum transaction is 2 cycles, with zero-wait slave `ready` at N+1. IDLE at N+2.
- Back-to-back from the same master: the next grant is at N+3 at the earliest. Under round-robin, a waiting other master gets N+3 instead.
- Abort timing: GNT entered at G, no `s_ready` through G+TIMEOUT-1. ABORT is at G+TIMEOUT; IDLE at G+TIMEOUT+1.
- `s_ready` in the same cycle as `cnt == TIMEOUT-1`: a normal completion, no abort.
- `irq` is registered with the state (high exactly in the ABORT cycle). `err` rises the cycle after ABORT.

## Test plan
- Reset → all outputs 0, `grant`=00. Master 0 reads 0x1000, slave ready at once with `s_spo`=0x12345678 → `s_rd`=1 one cycle after the request, `m0_spo`=0x12345678 with `m0_ready` 1 cycle, IDLE after.
- Both masters request the same cycle, repeated 4 times with `FIXED_PRIO=0` → grant order 0,1,0,1. Repeat with `FIXED_PRIO=1` → order 0,0,0,0 while master 0 keeps requesting.
- Master 1 writes 0x2000 with data 0xCAFEBABE, slave ready after 5 wait cycles → `s_we` high 6 cycles, `s_d`=0xCAFEBABE, `m0_ready` stays 0 throughout.
- `TIMEOUT`=8, slave never ready, master 0 reads → ABORT exactly 8 cycles after the grant, `m0_spo`=0xFFFFFFFF, `irq` 1 cycle, `err`=1, `err_src`=0. `err_clr` → `err`=0.
- Slave ready exactly at `cnt`=7 with `TIMEOUT`=8 → normal completion, `irq`=0.
- Assert `rst` low on cycle 3 of a 10-wait transaction → `s_rd`=0 and `grant`=00 immediately. After release, the held request is re-granted to master 0.
